// File: rtl/dp_fifos_rst_responder_if.sv
// dp_fifos_rst_responder_if
//
// Purpose: groups the FIFO data-path handshake of dp_fifos_rst_responder
// into one bundle. The reset-handshake signals (fifo_rst_i and the busy/error
// flags) and clk/rst stay as plain ports on the FIFO itself.
//
// Signals:
//   wr_en_i, din_i        write strobe and write data
//   rd_en_i               read strobe
//   dout_o, valid_o       registered read data and its one-cycle valid pulse
//   full_o, empty_o       occupancy flags, also high while the side is busy
//   data_count_o          number of stored words
//   overflow_o            one-cycle pulse for a rejected write
//   underflow_o           one-cycle pulse for a rejected read
//
// Modports: master drives the strobes/data, slave is the FIFO.

interface dp_fifos_rst_responder_if #(
    parameter int DataWidth = 32,
    parameter int Depth     = 16
) ();

    localparam int CountWidth = $clog2(Depth) + 1;

    logic                  wr_en_i;
    logic [DataWidth-1:0]  din_i;
    logic                  rd_en_i;
    logic [DataWidth-1:0]  dout_o;
    logic                  valid_o;
    logic                  full_o;
    logic                  empty_o;
    logic [CountWidth-1:0] data_count_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output wr_en_i, din_i, rd_en_i,
        input  dout_o, valid_o, full_o, empty_o, data_count_o,
               overflow_o, underflow_o
    );

    modport slave (
        input  wr_en_i, din_i, rd_en_i,
        output dout_o, valid_o, full_o, empty_o, data_count_o,
               overflow_o, underflow_o
    );

endinterface

// File: rtl/dp_fifos_rst_responder.sv
// dp_fifos_rst_responder
//
// Purpose: single-clock FIFO acting as the responder end of the FIFO reset
// handshake. A level request on fifo_rst_i flushes the FIFO; after it falls,
// wr_rst_busy_o releases BusyCycles+1 cycles later and rd_rst_busy_o one
// cycle after that. Accesses are blocked while the matching side is busy.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   fifo_rst_i            FIFO reset request (level)
//   bus                   data-path handshake (dp_fifos_rst_responder_if.slave)
//   wr_rst_busy_o         write side in reset
//   rd_rst_busy_o         read side in reset
//   seeerr_sig_o          illegal state encoding detected
//   rst_short_err_o       sticky: fifo_rst_i pulse shorter than MinRstCycles
//
// Optional feature: define DP_FIFOS_RST_PULSE_CHECK_EN to build the
// fifo_rst_i pulse-width checker; otherwise rst_short_err_o is tied low.

module dp_fifos_rst_responder #(
    parameter int DataWidth     = 32,
    parameter int Depth         = 16,
    parameter int BusyCycles    = 4,
    parameter int MinRstCycles  = 3,
    parameter int StateBitWidth = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     fifo_rst_i,
    dp_fifos_rst_responder_if.slave  bus,
    output logic                     wr_rst_busy_o,
    output logic                     rd_rst_busy_o,
    output logic                     seeerr_sig_o,
    output logic                     rst_short_err_o
);

    localparam int PtrWidth     = $clog2(Depth);
    localparam int CountWidth   = PtrWidth + 1;
    localparam int BusyCntWidth = (BusyCycles > 1) ? $clog2(BusyCycles) : 1;

    typedef enum logic [StateBitWidth-1:0] {
        INIT       = 0,
        RST_ACTIVE = 1,
        BUSY_HOLD  = 2,
        RD_TAIL    = 3,
        READY      = 4,
        ERROR      = 5
    } state_e;

    // Kept as a plain vector so encodings 6 and 7 are representable and can
    // be caught as single-event upsets.
    logic [StateBitWidth-1:0] state_q, state_d;
    logic [BusyCntWidth-1:0]  busy_cnt_q, busy_cnt_d;
    logic [PtrWidth-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CountWidth-1:0]    count_q, count_d;
    logic [DataWidth-1:0]     dout_q, dout_d;
    logic                     valid_q, valid_d;
    logic                     overflow_q, overflow_d;
    logic                     underflow_q, underflow_d;
    logic [DataWidth-1:0]     mem_q [Depth];

    logic wr_busy, rd_busy, full, empty;
    logic wr_accept, rd_accept, flush;

    // Moore decode of the busy flags straight from the state register.
    assign wr_busy = !((state_q == RD_TAIL) || (state_q == READY));
    assign rd_busy = (state_q != READY);
    assign full    = wr_busy || (count_q == CountWidth'(Depth));
    assign empty   = rd_busy || (count_q == '0);

    assign wr_accept = bus.wr_en_i && !full  && !fifo_rst_i;
    assign rd_accept = bus.rd_en_i && !empty && !fifo_rst_i;

    // ERROR and the illegal encodings above it discard contents too.
    assign flush = fifo_rst_i || (state_q == RST_ACTIVE) || (state_q > READY);

    // Reset-handshake sequencing; a new request from any settled or
    // releasing state restarts the whole sequence.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        case (state_q)
            INIT: begin
                state_d    = BUSY_HOLD;
                busy_cnt_d = '0;
            end
            RST_ACTIVE: begin
                if (!fifo_rst_i) begin
                    state_d    = BUSY_HOLD;
                    busy_cnt_d = '0;
                end
            end
            BUSY_HOLD: begin
                if (busy_cnt_q == BusyCntWidth'(BusyCycles - 1)) begin
                    state_d = RD_TAIL;
                end else begin
                    busy_cnt_d = busy_cnt_q + BusyCntWidth'(1);
                end
            end
            RD_TAIL: state_d = READY;
            READY:   state_d = READY;
            ERROR:   state_d = INIT;
            default: state_d = ERROR;
        endcase
        if (fifo_rst_i && ((state_q == INIT) || (state_q == BUSY_HOLD) ||
                           (state_q == RD_TAIL) || (state_q == READY))) begin
            state_d = RST_ACTIVE;
        end
    end

    // Pointer, occupancy and read-port update. Rejection pulses are
    // suppressed while a reset request is present.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        valid_d     = rd_accept;
        overflow_d  = bus.wr_en_i && !wr_accept && !fifo_rst_i;
        underflow_d = bus.rd_en_i && !rd_accept && !fifo_rst_i;
        if (rd_accept) begin
            dout_d = mem_q[rd_ptr_q];
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
            if (rd_accept) rd_ptr_d = rd_ptr_q + PtrWidth'(1);
            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CountWidth'(1);
                2'b01:   count_d = count_q - CountWidth'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            busy_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= bus.din_i;
        end
    end

    assign bus.dout_o       = dout_q;
    assign bus.valid_o      = valid_q;
    assign bus.full_o       = full;
    assign bus.empty_o      = empty;
    assign bus.data_count_o = count_q;
    assign bus.overflow_o   = overflow_q;
    assign bus.underflow_o  = underflow_q;
    assign wr_rst_busy_o    = wr_busy;
    assign rd_rst_busy_o    = rd_busy;
    assign seeerr_sig_o     = (state_q == ERROR);

`ifdef DP_FIFOS_RST_PULSE_CHECK_EN
    localparam int RstLenWidth = $clog2(MinRstCycles + 1);

    logic [RstLenWidth-1:0] rst_len_q, rst_len_d;
    logic                   rst_short_err_q, rst_short_err_d;

    // Saturating high-time counter; judged on the first low sample.
    always_comb begin
        rst_len_d       = rst_len_q;
        rst_short_err_d = rst_short_err_q;
        if (fifo_rst_i) begin
            if (rst_len_q != RstLenWidth'(MinRstCycles)) begin
                rst_len_d = rst_len_q + RstLenWidth'(1);
            end
        end else begin
            rst_len_d = '0;
            if ((rst_len_q != '0) && (rst_len_q < RstLenWidth'(MinRstCycles))) begin
                rst_short_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rst_len_q       <= '0;
            rst_short_err_q <= 1'b0;
        end else begin
            rst_len_q       <= rst_len_d;
            rst_short_err_q <= rst_short_err_d;
        end
    end

    assign rst_short_err_o = rst_short_err_q;
`else
    // Only the pulse checker needs MinRstCycles.
    logic unused_min_rst_cycles;
    assign unused_min_rst_cycles = (MinRstCycles > 0);
    assign rst_short_err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_dp_fifos_rst_responder.sv
// tb_dp_fifos_rst_responder
//
// Bench for dp_fifos_rst_responder (DataWidth=32, Depth=16, BusyCycles=4).
// Reset release is driven from a vector table; steady-state traffic goes
// through a queue-based reference model whose expected read data is
// compared when valid_o appears. The reset-handshake corner cases are
// written out as short sequences.

module tb_dp_fifos_rst_responder;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int BUSY  = 4;

`ifdef DP_FIFOS_RST_PULSE_CHECK_EN
    localparam logic EXP_SHORT = 1'b1;
`else
    localparam logic EXP_SHORT = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    logic fifo_rst_i;
    logic wr_rst_busy, rd_rst_busy, seeerr_sig, rst_short_err;

    int checks   = 0;
    int failures = 0;

    logic          model_ready = 1'b0;
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_rd_q [$];

    typedef struct {
        logic          we;
        logic [DW-1:0] din;
        logic          re;
        logic          fr;
        logic          wrb;
        logic          rdb;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          unf;
        logic          valid;
        logic [DW-1:0] dout;
        logic [4:0]    count;
    } vec_t;

    vec_t vecs [8];

    dp_fifos_rst_responder_if #(.DataWidth(DW), .Depth(DEPTH)) bus_if ();

    dp_fifos_rst_responder #(
        .DataWidth(DW), .Depth(DEPTH), .BusyCycles(BUSY),
        .MinRstCycles(3), .StateBitWidth(3)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .fifo_rst_i      (fifo_rst_i),
        .bus             (bus_if.slave),
        .wr_rst_busy_o   (wr_rst_busy),
        .rd_rst_busy_o   (rd_rst_busy),
        .seeerr_sig_o    (seeerr_sig),
        .rst_short_err_o (rst_short_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input logic we, input logic [DW-1:0] d,
                               input logic re, input logic fr);
        bus_if.wr_en_i = we;
        bus_if.din_i   = d;
        bus_if.rd_en_i = re;
        fifo_rst_i     = fr;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_wr_busy"}, wr_rst_busy, 1);
        checkOutput({tag, "_rd_busy"}, rd_rst_busy, 1);
        checkOutput({tag, "_full"}, bus_if.full_o, 1);
        checkOutput({tag, "_empty"}, bus_if.empty_o, 1);
        checkOutput({tag, "_count"}, bus_if.data_count_o, 0);
        checkOutput({tag, "_valid"}, bus_if.valid_o, 0);
        checkOutput({tag, "_dout"}, bus_if.dout_o, 0);
        checkOutput({tag, "_ovf"}, bus_if.overflow_o, 0);
        checkOutput({tag, "_unf"}, bus_if.underflow_o, 0);
        checkOutput({tag, "_seeerr"}, seeerr_sig, 0);
        checkOutput({tag, "_short_err"}, rst_short_err, 0);
    endtask

    task automatic runVector(input int idx, input vec_t v);
        driveInputs(v.we, v.din, v.re, v.fr);
        @(posedge clk_i);
        #1;
        checkOutput($sformatf("v%0d_wr_busy", idx), wr_rst_busy, v.wrb);
        checkOutput($sformatf("v%0d_rd_busy", idx), rd_rst_busy, v.rdb);
        checkOutput($sformatf("v%0d_full", idx), bus_if.full_o, v.full);
        checkOutput($sformatf("v%0d_empty", idx), bus_if.empty_o, v.empty);
        checkOutput($sformatf("v%0d_ovf", idx), bus_if.overflow_o, v.ovf);
        checkOutput($sformatf("v%0d_unf", idx), bus_if.underflow_o, v.unf);
        checkOutput($sformatf("v%0d_valid", idx), bus_if.valid_o, v.valid);
        checkOutput($sformatf("v%0d_dout", idx), bus_if.dout_o, v.dout);
        checkOutput($sformatf("v%0d_count", idx), bus_if.data_count_o, v.count);
    endtask

    // One cycle of traffic against the reference model.
    task automatic applyStimulus(input logic we, input logic [DW-1:0] d,
                                 input logic re, input logic fr);
        logic full_m, empty_m, wacc, racc, exp_ovf, exp_unf;
        full_m  = !model_ready || (model_q.size() == DEPTH);
        empty_m = !model_ready || (model_q.size() == 0);
        wacc    = we && !full_m && !fr;
        racc    = re && !empty_m && !fr;
        exp_ovf = we && !wacc && !fr;
        exp_unf = re && !racc && !fr;
        if (racc) exp_rd_q.push_back(model_q.pop_front());
        if (wacc) model_q.push_back(d);
        if (fr) begin
            model_q.delete();
            model_ready = 1'b0;
        end
        driveInputs(we, d, re, fr);
        @(posedge clk_i);
        #1;
        checkOutput("sb_ovf", bus_if.overflow_o, exp_ovf);
        checkOutput("sb_unf", bus_if.underflow_o, exp_unf);
        checkOutput("sb_valid", bus_if.valid_o, racc);
        if (bus_if.valid_o && exp_rd_q.size() != 0) begin
            checkOutput("sb_dout", bus_if.dout_o, exp_rd_q.pop_front());
        end
        checkOutput("sb_count", bus_if.data_count_o, model_q.size());
        checkOutput("sb_full", bus_if.full_o,
                    !model_ready || (model_q.size() == DEPTH));
        checkOutput("sb_empty", bus_if.empty_o,
                    !model_ready || (model_q.size() == 0));
    endtask

    // Idle cycles after a reset request (or rst_i) drops: the k-th edge
    // sampling the request low is k=1.
    task automatic releaseCheck(input string tag);
        for (int k = 1; k <= BUSY + 2; k++) begin
            driveInputs(1'b0, '0, 1'b0, 1'b0);
            @(posedge clk_i);
            #1;
            checkOutput($sformatf("%s_wr_busy_k%0d", tag, k), wr_rst_busy, (k <= BUSY));
            checkOutput($sformatf("%s_rd_busy_k%0d", tag, k), rd_rst_busy, (k <= BUSY + 1));
        end
        model_ready = 1'b1;
        checkOutput({tag, "_full_after"}, bus_if.full_o, 0);
        checkOutput({tag, "_empty_after"}, bus_if.empty_o, 1);
        checkOutput({tag, "_count_after"}, bus_if.data_count_o, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic seen;

        vecs[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  5'd0};
        vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  5'd0};
        vecs[2] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  5'd0};
        vecs[3] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  5'd0};
        vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  5'd0};
        vecs[5] = '{1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  5'd1};
        vecs[6] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55, 5'd0};
        vecs[7] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h55, 5'd0};

        rst_i = 1'b1;
        driveInputs(1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        checkResetValues("por");
        rst_i = 1'b0;

        // Release timing and RD_TAIL write/read acceptance.
        for (int i = 0; i < 8; i++) runVector(i, vecs[i]);
        model_ready = 1'b1;

        // Fill, overflow once, drain in order.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hAA, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous read+write at full and at empty.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DW'(100 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h99, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h77, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Reset request with writes pending, then a restart mid-BUSY_HOLD.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(200 + i), 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) applyStimulus(1'b1, 32'hDEAD, (j == 1), 1'b1);
        releaseCheck("frst");
        checkOutput("frst_short_err", rst_short_err, 0);
        for (int j = 0; j < 3; j++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("restart_hold1_wr_busy", wr_rst_busy, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("restart_hold2_wr_busy", wr_rst_busy, 1);
        for (int j = 0; j < 3; j++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        releaseCheck("restart");

        // Illegal state encoding.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(300 + i), 1'b0, 1'b0);
        driveInputs(1'b0, '0, 1'b0, 1'b0);
        force dut.state_q = 3'd7;
        @(posedge clk_i);
        #1;
        release dut.state_q;
        #1;
        seen = seeerr_sig;
        for (int n = 0; n < 4 && !seen; n++) begin
            @(posedge clk_i);
            #1;
            seen = seeerr_sig;
        end
        checkOutput("see_flag_seen", seen, 1);
        @(posedge clk_i);
        #1;
        checkOutput("see_flag_one_cycle", seeerr_sig, 0);
        checkOutput("see_init_wr_busy", wr_rst_busy, 1);
        checkOutput("see_init_rd_busy", rd_rst_busy, 1);
        checkOutput("see_flushed_count", bus_if.data_count_o, 0);
        model_q.delete();
        model_ready = 1'b0;
        releaseCheck("see");

        // Short reset pulse, then rst_i with data stored.
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, DW'(400 + i), 1'b0, 1'b0);
        for (int j = 0; j < 2; j++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        releaseCheck("short");
        checkOutput("short_err_set", rst_short_err, EXP_SHORT);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(500 + i), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("short_err_sticky", rst_short_err, EXP_SHORT);
        driveInputs(1'b0, '0, 1'b0, 1'b0);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checkResetValues("rst_mid");
        rst_i = 1'b0;
        model_q.delete();
        exp_rd_q.delete();
        model_ready = 1'b0;
        releaseCheck("rst_rel");
        checkOutput("sb_drained", exp_rd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dp_fifos_rst_responder.md
Name: dp_fifos_rst_responder

Overview:
Single-clock FIFO that is the responder end of the FIFO reset handshake. It accepts a level reset request (fifo_rst_i) from a reset sequencer and reports reset progress on wr_rst_busy_o / rd_rst_busy_o. It blocks writes and reads while busy. It is used wherever the wishbone datapath needs a FIFO that obeys the same reset/busy protocol as the generated dual-port FIFOs, and it doubles as a behavioural peer for verifying reset sequencers.

Parameters:
DataWidth, 32, data word width
Depth, 16, FIFO entries; power of 2, at least 4
BusyCycles, 4, number of cycles wr_rst_busy_o stays high after fifo_rst_i falls; at least 1
MinRstCycles, 3, minimum legal fifo_rst_i high width; used only by the optional check
StateBitWidth, 3, FSM state width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
fifo_rst_i  in  1  FIFO reset request, level, synchronous to clk_i
wr_en_i  in  1  write strobe
din_i  in  DataWidth  write data
rd_en_i  in  1  read strobe
dout_o  out  DataWidth  read data, registered
valid_o  out  1  dout_o valid, one-cycle pulse per accepted read
full_o  out  1  FIFO full, or write side busy
empty_o  out  1  FIFO empty, or read side busy
data_count_o  out  $clog2(Depth)+1  number of stored words
overflow_o  out  1  one-cycle pulse when a write is rejected
underflow_o  out  1  one-cycle pulse when a read is rejected
wr_rst_busy_o  out  1  write side in reset
rd_rst_busy_o  out  1  read side in reset
seeerr_sig_o  out  1  illegal FSM encoding detected (SEE)
rst_short_err_o  out  1  sticky flag: fifo_rst_i pulse was too short (optional feature)

Behaviour:
- Clock and reset: one clock (clk_i). rst_i is synchronous and active-high. rst_i has priority over every other input.
- Values while rst_i is high:
  - state = INIT
  - pointers and data_count_o = 0
  - dout_o = 0, valid_o = 0
  - overflow_o = 0, underflow_o = 0
  - rst_short_err_o = 0
  - decoded outputs: wr_rst_busy_o = 1, rd_rst_busy_o = 1, full_o = 1, empty_o = 1, seeerr_sig_o = 0
- FSM state encodings (Moore; busy and seeerr outputs decoded from state):
  - INIT = 0: both busy high. Next edge goes to BUSY_HOLD with the counter cleared.
  - RST_ACTIVE = 1: both busy high. Pointers and count are held at 0 and valid_o is cleared. Stays here while fifo_rst_i = 1; when it falls, goes to BUSY_HOLD with the counter cleared.
  - BUSY_HOLD = 2: both busy high. The counter increments each cycle; after BusyCycles cycles the FSM goes to RD_TAIL.
  - RD_TAIL = 3: wr_rst_busy_o = 0, rd_rst_busy_o = 1. Lasts one cycle, then goes to READY.
  - READY = 4: both busy low; normal operation.
  - ERROR = 5: seeerr_sig_o = 1 for one cycle, then INIT. This flushes the FIFO.
  - Encodings 6 and 7 go to ERROR on the next edge.
- fifo_rst_i = 1 sampled in INIT, BUSY_HOLD, RD_TAIL or READY goes to RST_ACTIVE on that edge. Contents are discarded and the count is cleared. A fifo_rst_i arriving mid-BUSY_HOLD restarts the sequence.
- Reset timing: from a fifo_rst_i falling edge, wr_rst_busy_o goes low exactly BusyCycles+1 cycles later and rd_rst_busy_o exactly BusyCycles+2 cycles later. The same offsets apply from rst_i deassertion.
- Flags: full_o = wr_rst_busy_o OR (count == Depth). empty_o = rd_rst_busy_o OR (count == 0).
- Write acceptance: a write is accepted when wr_en_i AND NOT full_o AND fifo_rst_i = 0. Writes are therefore allowed in RD_TAIL.
- Read acceptance: a read is accepted when rd_en_i AND NOT empty_o AND fifo_rst_i = 0.
- Read latency is 1: dout_o and valid_o update on the edge after the accepted read. dout_o holds its value when there is no read.
- Rejected write: wr_en_i high and not accepted gives overflow_o high on the next cycle. Rejected read: rd_en_i high and not accepted gives underflow_o high on the next cycle.
- No overflow_o or underflow_o is raised on any cycle where fifo_rst_i = 1.
- Simultaneous accepted read and write: count is unchanged.
- At full: a simultaneous read is accepted and the write is rejected (full_o is evaluated before the read).
- At empty: a simultaneous write is accepted and the read is rejected.
- Pointers are $clog2(Depth) bits and wrap naturally. data_count_o never exceeds Depth.

Optional Feature:
- Macro: DP_FIFOS_RST_PULSE_CHECK_EN.
- When defined: a saturating counter measures each fifo_rst_i high period. If fifo_rst_i falls after fewer than MinRstCycles high cycles, rst_short_err_o goes high on the next edge and stays high until rst_i. The reset sequence itself is unaffected.
- When undefined: rst_short_err_o is tied to 0 and the counter is not synthesised.

Test Plan:
1. Release rst_i, then idle with BusyCycles=4 -> wr_rst_busy_o low at cycle 5 and rd_rst_busy_o low at cycle 6; full_o = 0 and empty_o = 1 after that.
2. In READY, write 16 words 0x0..0xF; then drive wr_en_i with din_i = 0xAA while full -> data_count_o = 16, full_o = 1, overflow_o pulses once. Read 16 words -> dout_o = 0x0..0xF each one cycle after rd_en_i; empty_o = 1.
3. At count 16, assert rd_en_i and wr_en_i together -> one word read, write rejected, overflow_o = 1, count = 15. At count 0, do the same -> write accepted, underflow_o = 1, count = 1.
4. With 5 words stored, hold fifo_rst_i high for 3 cycles while wr_en_i = 1 -> count = 0, no overflow_o, busy sequence restarts with the same offsets as scenario 1. Pulse fifo_rst_i again during BUSY_HOLD -> busy release is delayed accordingly.
5. Force the state register to 7 -> ERROR for one cycle with seeerr_sig_o = 1, then INIT; the busy sequence completes and the FIFO is empty.
6. With DP_FIFOS_RST_PULSE_CHECK_EN defined, hold fifo_rst_i high for 2 cycles -> rst_short_err_o = 1 until rst_i. Hold it for 3 cycles -> stays 0. With the macro undefined -> rst_short_err_o is always 0.
